// File: rtl/dsc_op_sequencer.sv
// dsc_op_sequencer
//   Runs the DSC multiply core for exactly one operation per accepted
//   operand vector. The core is held in reset for one cycle with the
//   operands already applied. It is then enabled until it reports
//   op_finished, until an optional cycle cap is reached, or until the
//   cycle counter saturates (watchdog). The captured result and the
//   number of enabled cycles are presented on a valid/ready port.
//
//   WXIP1 must be at least DATA_WIDTH*NUM_INPUTS+1 so the core result fits.
//
// Ports
//   gclk, rst          clock, synchronous active-high reset
//   in_valid/in_ready  operand vector handshake
//   in_data            packed operands, operand i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cyc_limit          cycle cap sampled on accept, 0 = run until op_finished
//   core_rst, core_en  reset / enable to the core
//   core_data_in       operands to the core, same packing as in_data
//   core_data_out      core result
//   core_op_finished   core completion flag
//   res_valid/res_ready result handshake
//   res_data           core result captured at termination
//   res_cycles         enabled cycles, including the terminating one
//   res_truncated      stopped by cap or watchdog rather than op_finished
//   busy               an operation is in progress or its result is pending
//
// state | meaning
// IDLE  | core held in reset, waiting for an operand vector
// CLEAR | one cycle of core reset with operands stable, counter cleared
// RUN   | core enabled, counting cycles, watching for a stop condition
// HOLD  | result presented, waiting for res_ready

module dsc_op_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 2,
   parameter int WXIP1      = 17
) (
   input  logic                             gclk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [WXIP1-1:0]                 cyc_limit,
   output logic                             core_rst,
   output logic                             core_en,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
   input  logic [WXIP1-1:0]                 core_data_out,
   input  logic                             core_op_finished,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [WXIP1-1:0]                 res_data,
   output logic [WXIP1-1:0]                 res_cycles,
   output logic                             res_truncated,
   output logic                             busy
);

   localparam logic [WXIP1-1:0] CNT_ONE = WXIP1'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t           state;
   logic [WXIP1-1:0] cycle_cnt;
   // Cap timer counts down from cyc_limit; it reaches 1 on the RUN cycle
   // where the enabled-cycle count equals cyc_limit.
   logic [WXIP1-1:0] cap_remaining;
   logic             cap_armed;

   logic cap_hit;
   logic watchdog_hit;
   logic run_stop;

   assign cap_hit      = cap_armed && (cap_remaining == CNT_ONE);
   // A cap larger than the counter range can never be hit first, so the
   // saturating watchdog covers it.
   assign watchdog_hit = &cycle_cnt;
   assign run_stop     = core_op_finished || cap_hit || watchdog_hit;

   always_ff @(posedge gclk) begin
      if (rst) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         core_rst      <= 1'b1;
         core_en       <= 1'b0;
         core_data_in  <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_cycles    <= '0;
         res_truncated <= 1'b0;
         busy          <= 1'b0;
         cycle_cnt     <= '0;
         cap_remaining <= '0;
         cap_armed     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready  <= 1'b1;
               core_rst  <= 1'b1;
               core_en   <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
               if (in_valid && in_ready) begin
                  core_data_in  <= in_data;
                  cap_remaining <= cyc_limit;
                  cap_armed     <= |cyc_limit;
                  cycle_cnt     <= '0;
                  in_ready      <= 1'b0;
                  busy          <= 1'b1;
                  state         <= CLEAR;
               end
            end

            CLEAR: begin
               // Counter reads 1 on the first enabled cycle.
               cycle_cnt <= CNT_ONE;
               core_rst  <= 1'b0;
               core_en   <= 1'b1;
               state     <= RUN;
            end

            RUN: begin
               if (run_stop) begin
                  res_data      <= core_data_out;
                  res_cycles    <= cycle_cnt;
                  // A core finish wins over a cap/watchdog hit in the same cycle.
                  res_truncated <= !core_op_finished;
                  res_valid     <= 1'b1;
                  core_en       <= 1'b0;
                  core_rst      <= 1'b1;
                  state         <= HOLD;
               end else begin
                  cycle_cnt     <= cycle_cnt + CNT_ONE;
                  cap_remaining <= cap_remaining - CNT_ONE;
               end
            end

            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsc_op_sequencer.sv
module tb_dsc_op_sequencer;

   localparam int          WD_A   = 131071;
   localparam logic [31:0] MASK_A = 32'h1ffff;

   logic gclk = 1'b0;
   always #5 gclk = ~gclk;

   logic rst;

   // instance A: default parameters
   logic        in_valid, in_ready;
   logic [15:0] in_data;
   logic [16:0] cyc_limit;
   logic        core_rst, core_en;
   logic [15:0] core_data_in;
   logic [16:0] core_data_out;
   logic        core_op_finished;
   logic        res_valid, res_ready;
   logic [16:0] res_data, res_cycles;
   logic        res_truncated, busy;

   // instance B: 5-bit counter to reach the watchdog quickly
   logic        in_valid_b, in_ready_b;
   logic [3:0]  in_data_b;
   logic [4:0]  cyc_limit_b;
   logic        core_rst_b, core_en_b;
   logic [3:0]  core_data_in_b;
   logic [4:0]  core_data_out_b;
   logic        core_op_finished_b;
   logic        res_valid_b, res_ready_b;
   logic [4:0]  res_data_b, res_cycles_b;
   logic        res_truncated_b, busy_b;

   dsc_op_sequencer dut (
      .gclk(gclk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cyc_limit(cyc_limit),
      .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
      .core_data_out(core_data_out), .core_op_finished(core_op_finished),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_cycles(res_cycles), .res_truncated(res_truncated), .busy(busy)
   );

   dsc_op_sequencer #(.DATA_WIDTH(2), .NUM_INPUTS(2), .WXIP1(5)) dut_b (
      .gclk(gclk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .cyc_limit(cyc_limit_b),
      .core_rst(core_rst_b), .core_en(core_en_b), .core_data_in(core_data_in_b),
      .core_data_out(core_data_out_b), .core_op_finished(core_op_finished_b),
      .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
      .res_cycles(res_cycles_b), .res_truncated(res_truncated_b), .busy(busy_b)
   );

   // Core stub A: counts enabled cycles since core reset; finishes on
   // enabled cycle stub_fin_at (0 = never) with result (a*b)<<4, otherwise
   // outputs the current enabled-cycle number.
   int          stub_fin_at = 0;
   int          en_total = 0;
   logic [16:0] en_cnt;
   logic [31:0] stub_k;
   logic [31:0] stub_prod;

   always_ff @(posedge gclk) begin
      if (core_rst) en_cnt <= '0;
      else if (core_en) en_cnt <= en_cnt + 17'd1;
      if (core_en) en_total <= en_total + 1;
   end

   always_comb begin
      stub_k           = 32'(en_cnt) + 32'd1;
      stub_prod        = 32'(core_data_in[7:0]) * 32'(core_data_in[15:8]);
      core_op_finished = core_en && (stub_fin_at != 0) && (stub_k >= 32'(stub_fin_at));
      core_data_out    = core_op_finished ? 17'(stub_prod << 4) : 17'(stub_k);
   end

   // Core stub B: never finishes, outputs the enabled-cycle number.
   logic [4:0] en_cnt_b;
   always_ff @(posedge gclk) begin
      if (core_rst_b) en_cnt_b <= '0;
      else if (core_en_b) en_cnt_b <= en_cnt_b + 5'd1;
   end
   assign core_op_finished_b = 1'b0;
   assign core_data_out_b    = en_cnt_b + 5'd1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the operation stops at the earliest of finish, cap, watchdog;
   // a finish on the stopping cycle means not truncated.
   function automatic void model(input int a, input int b, input int fin_at, input int cap,
                                 input int wd, input logic [31:0] mask,
                                 output int cyc, output int data, output int trunc);
      int  stop;
      bit  fin;
      stop = wd;
      fin  = 1'b0;
      if (cap != 0 && cap < stop) stop = cap;
      if (fin_at != 0 && fin_at <= stop) begin
         stop = fin_at;
         fin  = 1'b1;
      end
      cyc   = stop;
      trunc = fin ? 0 : 1;
      data  = fin ? int'((32'(a * b) << 4) & mask) : int'(32'(stop) & mask);
   endfunction

   task automatic run_op(input int a, input int b, input int fin_at, input int cap,
                         input int hold, input string tag);
      int         cyc, data, trunc, lat, en0;
      bit         got;
      logic [7:0] a8, b8;
      a8 = 8'(a);
      b8 = 8'(b);
      model(int'(a8), int'(b8), fin_at, cap, WD_A, MASK_A, cyc, data, trunc);
      stub_fin_at = fin_at;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready) begin got = 1'b1; break; end
         @(negedge gclk);
      end
      check({tag, "/in_ready_wait"}, 32'(got), 32'd1);
      in_valid  = 1'b1;
      in_data   = {b8, a8};
      cyc_limit = 17'(cap);
      en0       = en_total;
      @(negedge gclk);
      in_valid  = 1'b0;
      in_data   = 16'($urandom);
      cyc_limit = 17'($urandom);
      check({tag, "/clear_busy"}, 32'(busy), 32'd1);
      check({tag, "/clear_en"}, 32'(core_en), 32'd0);
      check({tag, "/clear_rst"}, 32'(core_rst), 32'd1);
      check({tag, "/clear_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/core_data_in"}, 32'(core_data_in), 32'({b8, a8}));
      @(negedge gclk);
      check({tag, "/run_en"}, 32'(core_en), 32'd1);
      check({tag, "/run_rst"}, 32'(core_rst), 32'd0);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge gclk);
         lat++;
         if (res_valid) begin got = 1'b1; break; end
      end
      check({tag, "/res_valid_timeout"}, 32'(got), 32'd1);
      if (!got) return;
      check({tag, "/latency"}, 32'(lat), 32'(cyc));
      check({tag, "/res_cycles"}, 32'(res_cycles), 32'(cyc));
      check({tag, "/res_data"}, 32'(res_data), 32'(data));
      check({tag, "/res_truncated"}, 32'(res_truncated), 32'(trunc));
      check({tag, "/en_count"}, 32'(en_total - en0), 32'(cyc));
      check({tag, "/hold_en"}, 32'(core_en), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge gclk);
         check({tag, "/hold_valid"}, 32'(res_valid), 32'd1);
         check({tag, "/hold_data"}, 32'(res_data), 32'(data));
         check({tag, "/hold_cycles"}, 32'(res_cycles), 32'(cyc));
         check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
         check({tag, "/hold_core_en"}, 32'(core_en), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge gclk);
      res_ready = 1'b0;
      check({tag, "/release_valid"}, 32'(res_valid), 32'd0);
      check({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "/release_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int  fin, cap, lat;
      bit  got, saw_rv;

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      cyc_limit   = '0;
      res_ready   = 1'b0;
      in_valid_b  = 1'b0;
      in_data_b   = '0;
      cyc_limit_b = '0;
      res_ready_b = 1'b0;

      repeat (3) @(negedge gclk);
      check("rst/in_ready", 32'(in_ready), 32'd0);
      check("rst/core_rst", 32'(core_rst), 32'd1);
      check("rst/core_en", 32'(core_en), 32'd0);
      check("rst/core_data_in", 32'(core_data_in), 32'd0);
      check("rst/res_valid", 32'(res_valid), 32'd0);
      check("rst/res_data", 32'(res_data), 32'd0);
      check("rst/res_cycles", 32'(res_cycles), 32'd0);
      check("rst/res_truncated", 32'(res_truncated), 32'd0);
      check("rst/busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge gclk);
      check("post_rst/core_rst", 32'(core_rst), 32'd1);
      check("post_rst/core_en", 32'(core_en), 32'd0);
      check("post_rst/busy", 32'(busy), 32'd0);
      check("post_rst/res_valid", 32'(res_valid), 32'd0);

      run_op(3, 5, 20, 0, 0, "t1_finish");
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 10, 0, "t2_cap");
      run_op(6, 7, 20, 20, 1, "t3_tie");
      run_op(7, 9, 12, 0, 5, "t4_hold");
      run_op(8'hff, 8'h01, 0, 15, 1, "t4_b2b");

      // reset in the middle of RUN
      stub_fin_at = 0;
      in_valid  = 1'b1;
      in_data   = 16'h2211;
      cyc_limit = '0;
      @(negedge gclk);
      in_valid = 1'b0;
      @(negedge gclk);
      repeat (6) @(negedge gclk);
      check("t5/en_before_rst", 32'(core_en), 32'd1);
      rst = 1'b1;
      @(negedge gclk);
      rst = 1'b0;
      check("t5/core_en", 32'(core_en), 32'd0);
      check("t5/core_rst", 32'(core_rst), 32'd1);
      check("t5/res_valid", 32'(res_valid), 32'd0);
      check("t5/busy", 32'(busy), 32'd0);
      check("t5/in_ready_in_rst", 32'(in_ready), 32'd0);
      check("t5/core_data_in", 32'(core_data_in), 32'd0);
      check("t5/res_data", 32'(res_data), 32'd0);
      got = 1'b0;
      saw_rv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge gclk);
         if (res_valid) saw_rv = 1'b1;
         if (in_ready) got = 1'b1;
      end
      check("t5/in_ready_after", 32'(got), 32'd1);
      check("t5/no_result", 32'(saw_rv), 32'd0);
      check("t5/core_en_idle", 32'(core_en), 32'd0);

      for (int n = 0; n < 12; n++) begin
         fin = int'($urandom_range(0, 40));
         cap = int'($urandom_range(0, 40));
         if (fin == 0 && cap == 0) cap = 1;
         run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), fin, cap,
                int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
      end

      // watchdog on the 5-bit instance
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready_b) begin got = 1'b1; break; end
         @(negedge gclk);
      end
      check("t6/in_ready_wait", 32'(got), 32'd1);
      in_valid_b  = 1'b1;
      in_data_b   = 4'b1011;
      cyc_limit_b = 5'd0;
      @(negedge gclk);
      in_valid_b = 1'b0;
      in_data_b  = 4'b0000;
      check("t6/core_data_in", 32'(core_data_in_b), 32'hb);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge gclk);
         lat++;
         if (res_valid_b) begin got = 1'b1; break; end
      end
      check("t6/res_valid_timeout", 32'(got), 32'd1);
      check("t6/latency", 32'(lat), 32'd32);
      check("t6/res_cycles", 32'(res_cycles_b), 32'd31);
      check("t6/res_truncated", 32'(res_truncated_b), 32'd1);
      check("t6/res_data", 32'(res_data_b), 32'd31);
      res_ready_b = 1'b1;
      @(negedge gclk);
      res_ready_b = 1'b0;
      check("t6/release_valid", 32'(res_valid_b), 32'd0);
      check("t6/release_busy", 32'(busy_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dsc_op_sequencer.md
Name: dsc_op_sequencer

Overview:
- Upstream/downstream wrapper for the DSC `core` multiply engine.
- Accepts one operand vector per operation over a valid/ready handshake.
- Drives the core's `rst`/`en`/`bin_data_in` for exactly one operation and counts enabled cycles.
- Stops on `op_finished` or on a programmable cycle cap, then presents result and cycle count on a valid/ready output port.

Parameters:
- DATA_WIDTH, 8: width of each operand.
- NUM_INPUTS, 2: number of operands per operation.
- WXIP1, 17: result and cycle-counter width; must be ≥ DATA_WIDTH*NUM_INPUTS+1.

Ports:
- gclk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: operand vector valid.
- in_ready  out  1: sequencer can accept an operand vector.
- in_data  in  NUM_INPUTS*DATA_WIDTH: packed operands; operand i at [i*DATA_WIDTH +: DATA_WIDTH].
- cyc_limit  in  WXIP1: cycle cap, sampled on accept; 0 means run to op_finished.
- core_rst  out  1: to core rst.
- core_en  out  1: to core en.
- core_data_in  out  NUM_INPUTS*DATA_WIDTH: to core bin_data_in, same packing as in_data.
- core_data_out  in  WXIP1: from core bin_data_out.
- core_op_finished  in  1: from core op_finished.
- res_valid  out  1: result valid.
- res_ready  in  1: consumer accepts result.
- res_data  out  WXIP1: captured core output.
- res_cycles  out  WXIP1: number of cycles core_en was high, including the terminating cycle.
- res_truncated  out  1: operation stopped by cap or watchdog, not by op_finished.
- busy  out  1: state != IDLE.

Behaviour:
- All outputs and state are registered. gclk rising edge only; rst is sampled synchronously.
- Values while rst is high and on the first cycle after it:
  - state = IDLE; core_rst = 1; core_en = 0.
  - core_data_in = 0; res_valid = 0; res_data = 0; res_cycles = 0; res_truncated = 0; busy = 0.
  - in_ready = 0 while rst is high.
- FSM states: IDLE, CLEAR, RUN, HOLD.
- IDLE:
  - in_ready = 1, core_rst = 1, core_en = 0.
  - On in_valid && in_ready: latch in_data into core_data_in, latch cyc_limit, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - core_rst = 1, core_en = 0, operands held stable at the core.
  - Internal counter cleared to 0. Go to RUN.
- RUN:
  - core_rst = 0, core_en = 1.
  - Counter increments every RUN cycle; value is 1 on the first RUN cycle.
  - Terminate in the cycle where any of these holds:
    - (a) core_op_finished = 1;
    - (b) cyc_limit != 0 && counter == cyc_limit;
    - (c) counter == all-ones (watchdog).
  - On termination:
    - capture res_data = core_data_out;
    - capture res_cycles = counter;
    - capture res_truncated = !core_op_finished;
    - go to HOLD.
  - If (a) and (b)/(c) are true in the same cycle, res_truncated = 0.
- HOLD:
  - res_valid = 1, core_en = 0, core_rst = 1.
  - res_* held stable until res_ready. On res_ready, go to IDLE; res_valid = 0 the next cycle.
  - in_ready = 0 throughout HOLD; there is no overlap of operations.
- Timing:
  - Accept at edge T. CLEAR during T+1. First core_en = 1 cycle is T+2.
  - res_valid rises one cycle after the terminating RUN cycle.
  - core_en falls in the same cycle res_valid rises.
- core_data_in changes only on accept or reset.
- Reset mid-operation in any state: next cycle matches the reset values above. The captured result is discarded; no partial res_valid is emitted.
- cyc_limit greater than the watchdog value is treated the same as the watchdog.

Test Plan:
1. Core stub asserts op_finished at enabled cycle 20 with data 0x0F0; operands 3, 5; cyc_limit = 0 -> res_data = 0x0F0, res_cycles = 20, res_truncated = 0; core_en high for exactly 20 cycles starting at T+2.
2. Stub never finishes; cyc_limit = 10 -> res_cycles = 10, res_truncated = 1, res_data = stub value at enabled cycle 10.
3. cyc_limit = 20 and stub finishes at cycle 20 -> res_truncated = 0, res_cycles = 20.
4. res_ready held low for 5 cycles after res_valid -> res_* stable, in_ready = 0, core_en = 0. Then res_ready pulsed 1 cycle -> IDLE; a back-to-back in_valid is accepted the following cycle, with operands 0xFF, 0x01.
5. rst asserted at enabled cycle 7 -> next cycle core_en = 0, core_rst = 1, res_valid = 0, busy = 0; in_ready = 1 after rst drops; no result emitted.
6. WXIP1 = 5, cyc_limit = 0, stub never finishes -> res_cycles = 31, res_truncated = 1 (watchdog).
